register_file_param: RTL and testbench
======================================

REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning address width, with DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter N_RD, default 2, meaning number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_R0, default 1, meaning that when set, register 0 reads as 0 and ignores writes.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-007 SHALL have port rd_addr, input, N_RD*ADDR_W bits, meaning the read addresses, with port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data, output, N_RD*DATA_W bits, meaning the read data, with port i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port wr_en, input, 1 bit, meaning write request.
REQ-010 SHALL have port wr_addr, input, ADDR_W bits, meaning write address.
REQ-011 SHALL have port wr_data, input, DATA_W bits, meaning write data.
REQ-012 SHALL have port clr_req, input, 1 bit, meaning a request to zero all registers.
REQ-013 SHALL have port busy, output, 1 bit, meaning a clear sweep is in progress.
REQ-014 SHALL have port wr_err, output, 1 bit, meaning a one-cycle pulse when a write is dropped.

Function
REQ-015 SHALL implement FSM states CLEAR and READY only.
REQ-016 In CLEAR, SHALL write 0 to entry clr_ptr each cycle and increment clr_ptr, wrapping at DEPTH-1.
REQ-017 In CLEAR, after the cycle that clears DEPTH-1, SHALL enter READY, deasserting busy on that same edge.
REQ-018 A CLEAR sweep SHALL take exactly DEPTH cycles.
REQ-019 busy SHALL be 1 if and only if state = CLEAR.
REQ-020 In READY, clr_req=1 SHALL set state to CLEAR and clr_ptr to 0 on the next edge; the accompanying wr_en in that cycle SHALL still be performed.
REQ-021 clr_req while in CLEAR SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-022 Writes SHALL be synchronous: in READY with wr_en=1, registers[wr_addr] <= wr_data on the rising edge.
REQ-023 With ZERO_R0=1 and wr_addr=0, a write SHALL be discarded silently, without asserting wr_err.
REQ-024 A write with wr_en=1 while busy=1 SHALL be dropped, and wr_err SHALL be 1 for the following cycle only; otherwise wr_err SHALL be 0.
REQ-025 Reads SHALL be combinational: rd_data[i] = registers[rd_addr[i]].
REQ-026 Write bypass: when wr_en=1, a write is accepted this cycle (READY, address not suppressed) and rd_addr[i]=wr_addr, rd_data[i] SHALL equal wr_data in the same cycle.
REQ-027 With ZERO_R0=1 and rd_addr[i]=0, rd_data[i] SHALL be 0.
REQ-028 While busy=1, every rd_data[i] SHALL be 0, regardless of stored contents.
REQ-029 Multiple read ports addressing the same register SHALL return identical data.
REQ-030 There SHALL be no file I/O and no simulation-only constructs in the synthesizable body.

Reset
REQ-031 rst=1 SHALL immediately force state=CLEAR, clr_ptr=0 and wr_err=0, with busy=1 and all rd_data=0 while held.
REQ-032 The storage array SHALL NOT be asynchronously reset; it SHALL be zeroed by the CLEAR sweep that starts on the first edge after rst falls.
REQ-033 rst asserted mid-sweep or mid-operation SHALL restart the sweep from entry 0.

Verification (DATA_W=16, ADDR_W=4, N_RD=2, ZERO_R0=1)
REQ-034 Release rst, then hold inputs idle -> busy=1 for exactly 16 cycles, then 0; all 16 registers read 0x0000.
REQ-035 In READY, write 0xBEEF to r5 while rd_addr port0=5 -> rd_data port0=0xBEEF in the same cycle (bypass), and 0xBEEF on both ports next cycle.
REQ-036 Write 0x1234 to r0 -> reading r0 returns 0x0000 and wr_err stays 0.
REQ-037 Write r3=0x00AA, then assert clr_req for 1 cycle with wr_en=1, wr_addr=7, wr_data=0x0055 -> r7 is written, then busy=1 for 16 cycles; afterwards r3=r7=0x0000.
REQ-038 Attempt to write r9=0xFFFF during the sweep -> wr_err=1 for exactly one cycle, and r9 reads 0x0000 after the sweep.
REQ-039 Pulse rst at sweep cycle 10 -> clr_ptr returns to 0, and busy remains 1 for a full 16 cycles after release.

Source files
------------

// File: rtl/register_file_param.sv
// Parameterised register file with N_RD combinational read ports, one write port,
// write-through bypass, optional hard-zero r0, and a sequenced clear sweep.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | sweep zeroing one entry per cycle; reads return 0, writes drop
// ST_READY | normal operation; writes accepted, clr_req starts a new sweep
module register_file_param #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int N_RD    = 2,
   parameter int ZERO_R0 = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     wr_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

   logic [0:0]        state;
   logic [ADDR_W-1:0] clr_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              r0_hit;
   logic              wr_accept;

   assign busy      = (state == ST_CLEAR);
   assign r0_hit    = (ZERO_R0 != 0) && (wr_addr == '0);
   // r0 writes are swallowed silently; they are not an error
   assign wr_accept = (state == ST_READY) && wr_en && !r0_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_ptr <= '0;
         wr_err  <= 1'b0;
      end else begin
         wr_err <= (state == ST_CLEAR) && wr_en;
         case (state)
            ST_CLEAR: begin
               clr_ptr <= clr_ptr + PTR_ONE;
               if (clr_ptr == PTR_LAST) begin
                  state <= ST_READY;
               end
            end
            default: begin
               if (clr_req) begin
                  state   <= ST_CLEAR;
                  clr_ptr <= '0;
               end
            end
         endcase
      end
   end

   // Storage carries no reset; the sweep after reset release zeroes it.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_ptr] <= '0;
      end else if (wr_accept) begin
         mem[wr_addr] <= wr_data;
      end
   end

   for (genvar g = 0; g < N_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = rd_addr[g*ADDR_W +: ADDR_W];
      assign rd_data[g*DATA_W +: DATA_W] =
         busy                              ? '0      :
         ((ZERO_R0 != 0) && (ra == '0))    ? '0      :
         (wr_accept && (ra == wr_addr))    ? wr_data :
                                             mem[ra];
   end

endmodule

// File: tb/tb_register_file_param.sv
// Directed self-checking bench for register_file_param at its default parameters.
module tb_register_file_param;

   logic        clk;
   logic        rst;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic        clr_req;
   logic        busy;
   logic        wr_err;

   int n_pass;
   int n_total;
   int n;

   register_file_param #(
      .DATA_W(16), .ADDR_W(4), .N_RD(2), .ZERO_R0(1)
   ) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_req(clr_req), .busy(busy), .wr_err(wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
      rd_addr = {a1, a0};
      #1;
   endtask

   task automatic count_sweep(output int cycles);
      cycles = 0;
      while (busy && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
      wr_data = '0; clr_req = 1'b0;

      // held in reset
      tick(); tick();
      set_rd(4'd5, 4'd9);
      chk("rst_busy", {15'd0, busy}, 16'd1);
      chk("rst_wr_err", {15'd0, wr_err}, 16'd0);
      chk("rst_rd0", rd_data[15:0], 16'h0000);
      chk("rst_rd1", rd_data[31:16], 16'h0000);

      // initial sweep
      rst = 1'b0;
      count_sweep(n);
      chk("init_sweep_len", 16'(n), 16'd16);
      chk("init_busy_low", {15'd0, busy}, 16'd0);
      for (int i = 0; i < 16; i++) begin
         set_rd(4'(i), 4'(15 - i));
         chk($sformatf("init_zero_p0_r%0d", i), rd_data[15:0], 16'h0000);
         chk($sformatf("init_zero_p1_r%0d", 15 - i), rd_data[31:16], 16'h0000);
      end

      // bypass write to r5
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
      set_rd(4'd5, 4'd6);
      chk("bypass_p0", rd_data[15:0], 16'hBEEF);
      chk("bypass_p1_other", rd_data[31:16], 16'h0000);
      tick();
      wr_en = 1'b0;
      set_rd(4'd5, 4'd5);
      chk("r5_p0", rd_data[15:0], 16'hBEEF);
      chk("r5_p1", rd_data[31:16], 16'hBEEF);
      chk("r5_no_err", {15'd0, wr_err}, 16'd0);

      // r0 is hard zero
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234;
      set_rd(4'd0, 4'd5);
      chk("r0_bypass_blocked", rd_data[15:0], 16'h0000);
      tick();
      wr_en = 1'b0;
      set_rd(4'd0, 4'd0);
      chk("r0_read", rd_data[15:0], 16'h0000);
      chk("r0_wr_err", {15'd0, wr_err}, 16'd0);

      // r3 write, then clr_req with a concurrent write to r7
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h00AA;
      tick();
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0055; clr_req = 1'b1;
      set_rd(4'd7, 4'd3);
      chk("clr_cycle_bypass_r7", rd_data[15:0], 16'h0055);
      chk("clr_cycle_r3", rd_data[31:16], 16'h00AA);
      chk("clr_cycle_busy", {15'd0, busy}, 16'd0);
      tick();
      // sweep cycle 0: write r9 while busy, and a clr_req that must be ignored
      wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'hFFFF; clr_req = 1'b1;
      set_rd(4'd7, 4'd9);
      chk("sweep_busy", {15'd0, busy}, 16'd1);
      chk("sweep_rd_p0_zero", rd_data[15:0], 16'h0000);
      chk("sweep_rd_p1_zero", rd_data[31:16], 16'h0000);
      chk("sweep_err_before", {15'd0, wr_err}, 16'd0);
      tick();
      wr_en = 1'b0; clr_req = 1'b0;
      #1;
      chk("drop_err_pulse", {15'd0, wr_err}, 16'd1);
      tick();
      chk("drop_err_clears", {15'd0, wr_err}, 16'd0);
      n = 2;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      chk("clr_sweep_len", 16'(n), 16'd16);
      set_rd(4'd3, 4'd7);
      chk("after_clr_r3", rd_data[15:0], 16'h0000);
      chk("after_clr_r7", rd_data[31:16], 16'h0000);
      set_rd(4'd9, 4'd5);
      chk("after_clr_r9", rd_data[15:0], 16'h0000);
      chk("after_clr_r5", rd_data[31:16], 16'h0000);

      // reset in the middle of a sweep
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
      tick();
      wr_en = 1'b0; clr_req = 1'b1;
      set_rd(4'd5, 4'd0);
      chk("pre_rst_r5", rd_data[15:0], 16'hBEEF);
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0F0F;
      tick();
      chk("mid_sweep_err", {15'd0, wr_err}, 16'd1);
      wr_en = 1'b0; rst = 1'b1;
      #1;
      chk("mid_rst_err_cleared", {15'd0, wr_err}, 16'd0);
      chk("mid_rst_busy", {15'd0, busy}, 16'd1);
      chk("mid_rst_rd", rd_data[15:0], 16'h0000);
      tick();
      rst = 1'b0;
      count_sweep(n);
      chk("restart_sweep_len", 16'(n), 16'd16);
      set_rd(4'd5, 4'd2);
      chk("restart_r5", rd_data[15:0], 16'h0000);
      chk("restart_r2", rd_data[31:16], 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
